// File: rtl/cdr_symbol_timer.sv
`timescale 1ns/1ps
// cdr_symbol_timer
//   Symbol-timing counter for the CDR. A prescaler phase input marks tick
//   cycles; the counter advances once per tick and wraps after P_act ticks.
//   Single-clock strobes fire after the tick on which the count matches the
//   early (D), mid (M), late (F), phase-detector (E) and freq-synch (S)
//   positions, all decoded from P_act. A new period is taken from i_nb_P only
//   at the symbol wrap; illegal periods are rejected and flagged. A sticky
//   advance/retard request slips the next symbol by one tick.
//
// Ports
//   i_clk            clock
//   i_rst            asynchronous reset, active low
//   i_nb_P           requested period in ticks, sampled at wrap
//   i_cnt_p          prescaler phase; tick when equal to PRE_MAX
//   i_adv / i_ret    request one-tick shorter / longer next symbol
//   o_en_d           early sampling strobe
//   o_en_m           mid sampling strobe
//   o_en_f           late sampling strobe
//   o_en             phase-detector latch strobe
//   o_en_freq_synch  divider period-update strobe
//   o_cnt            current symbol count
//   o_period_err     pulse: i_nb_P rejected at wrap
module cdr_symbol_timer #(
  parameter int CNT_W   = 6,
  parameter int PRE_W   = 2,
  parameter int PRE_MAX = 3,
  parameter int P_DEF   = 24,
  parameter int MIN_P   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CNT_W-1:0] i_nb_P,
  input  logic [PRE_W-1:0] i_cnt_p,
  input  logic             i_adv,
  input  logic             i_ret,
  output logic             o_en_d,
  output logic             o_en_m,
  output logic             o_en_f,
  output logic             o_en,
  output logic             o_en_freq_synch,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_period_err
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] P_DEF_C   = CNT_W'(P_DEF);
  localparam logic [CNT_W-1:0] MIN_P_C   = CNT_W'(MIN_P);
  localparam logic [PRE_W-1:0] PRE_MAX_C = PRE_W'(PRE_MAX);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] p_act;
  logic [CNT_W-1:0] pos_d, pos_m, pos_f, pos_e, pos_s;
  logic             adv_pend, ret_pend;
  logic             hold0;
  logic             tick, wrap, nb_legal;
  logic             base_adv, base_ret;
  logic             adv_nxt, ret_nxt;

  always_comb begin
    tick     = (i_cnt_p == PRE_MAX_C);
    pos_s    = p_act - ONE;
    pos_d    = ONE;
    pos_m    = ((p_act - ONE) >> 1) - ONE;
    pos_f    = p_act - CNT_W'(4);
    pos_e    = p_act - CNT_W'(3);
    // The second tick spent at count 0 after a retard must not count as a wrap.
    wrap     = tick && !hold0 && (cnt == pos_s);
    nb_legal = (i_nb_P >= MIN_P_C);
  end

  // Pending flags are consumed at the wrap; a request on the wrap cycle is
  // judged against the already-cleared flags so it lands on the next symbol.
  always_comb begin
    base_adv = wrap ? 1'b0 : adv_pend;
    base_ret = wrap ? 1'b0 : ret_pend;
    adv_nxt  = base_adv;
    ret_nxt  = base_ret;
    if (i_adv && !i_ret) begin
      if (base_ret) begin
        adv_nxt = 1'b0;
        ret_nxt = 1'b0;
      end else begin
        adv_nxt = 1'b1;
      end
    end else if (i_ret && !i_adv) begin
      if (base_adv) begin
        adv_nxt = 1'b0;
        ret_nxt = 1'b0;
      end else begin
        ret_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt             <= '0;
      p_act           <= P_DEF_C;
      adv_pend        <= 1'b0;
      ret_pend        <= 1'b0;
      hold0           <= 1'b0;
      o_en_d          <= 1'b0;
      o_en_m          <= 1'b0;
      o_en_f          <= 1'b0;
      o_en            <= 1'b0;
      o_en_freq_synch <= 1'b0;
      o_period_err    <= 1'b0;
    end else begin
      o_en_d          <= tick && (cnt == pos_d);
      o_en_m          <= tick && (cnt == pos_m);
      o_en_f          <= tick && (cnt == pos_f);
      o_en            <= tick && (cnt == pos_e);
      o_en_freq_synch <= tick && (cnt == pos_s) && !hold0;
      o_period_err    <= wrap && !nb_legal;
      adv_pend        <= adv_nxt;
      ret_pend        <= ret_nxt;
      if (tick) begin
        if (hold0) begin
          hold0 <= 1'b0;
        end else if (cnt == pos_s) begin
          if (nb_legal) begin
            p_act <= i_nb_P;
          end
          cnt   <= adv_pend ? ONE : '0;
          hold0 <= ret_pend;
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end
  end

  assign o_cnt = cnt;

endmodule

// File: tb/tb_cdr_symbol_timer.sv
`timescale 1ns/1ps
module tb_cdr_symbol_timer;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [5:0] i_nb_P;
  logic [1:0] i_cnt_p;
  logic       i_adv, i_ret;
  logic       o_en_d, o_en_m, o_en_f, o_en, o_en_freq_synch, o_period_err;
  logic [5:0] o_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  cdr_symbol_timer #(
    .CNT_W(6), .PRE_W(2), .PRE_MAX(3), .P_DEF(24), .MIN_P(8)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_nb_P(i_nb_P), .i_cnt_p(i_cnt_p),
    .i_adv(i_adv), .i_ret(i_ret),
    .o_en_d(o_en_d), .o_en_m(o_en_m), .o_en_f(o_en_f), .o_en(o_en),
    .o_en_freq_synch(o_en_freq_synch), .o_cnt(o_cnt), .o_period_err(o_period_err)
  );

  // Request kinds: 0 none, 1 adv, 2 ret, 3 adv+ret same cycle.
  // Offsets are clocks from the S strobe that opens the measured symbol.
  typedef struct {
    int nb; int k1; int c1; int k2; int c2;
    int err; int start_cnt; int len;
    int od; int om; int o_f; int oe;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    i_cnt_p = i_cnt_p + 2'd1;
  endtask

  task automatic wait_s(input string nm);
    int t = 0;
    do begin
      step();
      t++;
    end while (!o_en_freq_synch && t < 400);
    chk({nm, " sync"}, int'(o_en_freq_synch), 1);
  endtask

  task automatic wait_cnt(input string nm, input int c);
    int t = 0;
    while (int'(o_cnt) != c && t < 400) begin
      step();
      t++;
    end
    chk({nm, " reach_cnt"}, int'(o_cnt), c);
  endtask

  task automatic pulse(input int k);
    i_adv = (k == 1 || k == 3);
    i_ret = (k == 2 || k == 3);
    step();
    i_adv = 1'b0;
    i_ret = 1'b0;
  endtask

  task automatic measure(input string nm, input int len_e, input int od_e,
                         input int om_e, input int of_e, input int oe_e);
    int t = 0;
    int od = -1, om = -1, o_f = -1, oe = -1;
    int nd = 0, nm_c = 0, nf = 0, ne = 0, nerr = 0;
    do begin
      step();
      t++;
      if (o_en_d) begin nd++; od = t; end
      if (o_en_m) begin nm_c++; om = t; end
      if (o_en_f) begin nf++; o_f = t; end
      if (o_en)   begin ne++; oe = t; end
      if (o_period_err && !o_en_freq_synch) nerr++;
    end while (!o_en_freq_synch && t < 400);
    chk({nm, " len"}, t, len_e);
    chk({nm, " off_d"}, od, od_e);
    chk({nm, " off_m"}, om, om_e);
    chk({nm, " off_f"}, o_f, of_e);
    chk({nm, " off_e"}, oe, oe_e);
    chk({nm, " cnt_d"}, nd, 1);
    chk({nm, " cnt_m"}, nm_c, 1);
    chk({nm, " cnt_f"}, nf, 1);
    chk({nm, " cnt_e"}, ne, 1);
    chk({nm, " stray_err"}, nerr, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " o_cnt"}, int'(o_cnt), 0);
    chk({nm, " strobes"}, int'({o_en_d, o_en_m, o_en_f, o_en, o_en_freq_synch}), 0);
    chk({nm, " o_period_err"}, int'(o_period_err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          nb  k1 c1 k2 c2 err st len  od  om  of   oe
    tbl[0]  = '{24, 0, 0, 0, 0, 0, 0, 96,  8, 44,  84,  88};
    tbl[1]  = '{16, 0, 0, 0, 0, 0, 0, 64,  8, 28,  52,  56};
    tbl[2]  = '{24, 1, 5, 0, 0, 0, 1, 92,  4, 40,  80,  84};
    tbl[3]  = '{24, 3, 5, 0, 0, 0, 0, 96,  8, 44,  84,  88};
    tbl[4]  = '{24, 2, 3, 1, 7, 0, 0, 96,  8, 44,  84,  88};
    tbl[5]  = '{24, 2, 5, 0, 0, 0, 0, 100, 12, 48, 88,  92};
    tbl[6]  = '{ 5, 0, 0, 0, 0, 1, 0, 96,  8, 44,  84,  88};
    tbl[7]  = '{63, 0, 0, 0, 0, 0, 0, 252, 8, 124, 240, 244};
    tbl[8]  = '{ 8, 0, 0, 0, 0, 0, 0, 32,  8, 12,  20,  24};
    tbl[9]  = '{ 7, 0, 0, 0, 0, 1, 0, 32,  8, 12,  20,  24};
    tbl[10] = '{24, 1, 2, 1, 4, 0, 1, 92,  4, 40,  80,  84};
    tbl[11] = '{24, 0, 0, 0, 0, 0, 0, 96,  8, 44,  84,  88};

    i_rst   = 1'b0;
    i_nb_P  = 6'd24;
    i_cnt_p = 2'd0;
    i_adv   = 1'b0;
    i_ret   = 1'b0;
    #12;
    chk_all_zero("reset");
    #20;
    i_rst = 1'b1;

    wait_s("init");

    for (int i = 0; i < 12; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      i_nb_P = 6'(tbl[i].nb);
      if (tbl[i].k1 != 0) begin
        wait_cnt(nm, tbl[i].c1);
        pulse(tbl[i].k1);
      end
      if (tbl[i].k2 != 0) begin
        wait_cnt(nm, tbl[i].c2);
        pulse(tbl[i].k2);
      end
      wait_s(nm);
      chk({nm, " period_err"}, int'(o_period_err), tbl[i].err);
      chk({nm, " start_cnt"}, int'(o_cnt), tbl[i].start_cnt);
      measure(nm, tbl[i].len, tbl[i].od, tbl[i].om, tbl[i].o_f, tbl[i].oe);
    end

    // Advance request on the wrap tick itself: next symbol unaffected,
    // the one after is one tick short.
    begin
      int t = 0;
      while (!(o_cnt == 6'd23 && i_cnt_p == 2'd3) && t < 400) begin
        step();
        t++;
      end
      chk("wrapreq find_wrap", int'(o_cnt), 23);
      i_adv = 1'b1;
      step();
      i_adv = 1'b0;
      chk("wrapreq sync", int'(o_en_freq_synch), 1);
      chk("wrapreq start_cnt0", int'(o_cnt), 0);
      measure("wrapreq sym1", 96, 8, 44, 84, 88);
      chk("wrapreq start_cnt1", int'(o_cnt), 1);
      measure("wrapreq sym2", 92, 4, 40, 80, 84);
    end

    // Reset mid-symbol while running a non-default period.
    i_nb_P = 6'd40;
    wait_s("rst_load40");
    wait_cnt("rst", 17);
    #3;
    i_rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    repeat (3) step();
    chk_all_zero("rst_held");
    #2;
    i_rst = 1'b1;
    begin
      int t = 0;
      while (!(o_en_d || o_en_m || o_en_f || o_en || o_en_freq_synch) && t < 400) begin
        step();
        t++;
      end
      chk("rst first_strobe_is_d", int'(o_en_d), 1);
      chk("rst first_strobe_cnt", int'(o_cnt), 2);
      t = 0;
      do begin
        step();
        t++;
      end while (!o_en_freq_synch && t < 400);
      chk("rst d_to_s_clocks", t, 88);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
